// File: rtl/faccel_job_seq.sv
// Bus-master sequencer: programs the factorial accelerator, waits for done, reads status/result.
// Optional FACCEL_SEQ_POLL_EN: WAIT polls STATUS over the bus instead of using bus_done.
module faccel_job_seq #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0800,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned TO_W           = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [3:0]  job_n,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    input  logic [31:0] bus_rdata,
    input  logic        bus_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_N,
        S_WR_GO,
        S_GO_CLR,
        S_WAIT,
        S_RD_STAT,
        S_RD_RES,
        S_RESP
    } state_t;

    localparam logic [31:0]     ADDR_N      = BASE_ADDR;
    localparam logic [31:0]     ADDR_GO     = BASE_ADDR + 32'h4;
    localparam logic [31:0]     ADDR_STATUS = BASE_ADDR + 32'h8;
    localparam logic [31:0]     ADDR_RESULT = BASE_ADDR + 32'hC;
    localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);

`ifdef FACCEL_SEQ_POLL_EN
    localparam logic [31:0] WAIT_ADDR = ADDR_STATUS;
    logic w_unused_done;
    assign w_unused_done = bus_done;
`else
    // Parked off the accelerator so the sticky done flag is not cleared while waiting.
    localparam logic [31:0] WAIT_ADDR = '0;
`endif

    state_t            r_state;
    logic [TO_W-1:0]   r_cnt;
    logic              r_res_valid;
    logic [31:0]       r_res_data;
    logic              r_res_err;
    logic [31:0]       r_bus_addr;
    logic [31:0]       r_bus_wdata;
    logic              r_bus_we;
    logic              w_wait_done;

`ifdef FACCEL_SEQ_POLL_EN
    assign w_wait_done = bus_rdata[0];
`else
    assign w_wait_done = bus_done;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_err   <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_we    <= 1'b0;
        end else begin
            // Bus outputs are loaded on the transition so they hold for the whole target state.
            case (r_state)
                S_IDLE: begin
                    if (job_valid) begin
                        r_state     <= S_WR_N;
                        r_bus_addr  <= ADDR_N;
                        r_bus_wdata <= {28'b0, job_n};
                        r_bus_we    <= 1'b1;
                    end
                end
                S_WR_N: begin
                    r_state     <= S_WR_GO;
                    r_bus_addr  <= ADDR_GO;
                    r_bus_wdata <= 32'd1;
                    r_bus_we    <= 1'b1;
                end
                S_WR_GO: begin
                    r_state     <= S_GO_CLR;
                    r_bus_addr  <= ADDR_GO;
                    r_bus_wdata <= '0;
                    r_bus_we    <= 1'b1;
                end
                S_GO_CLR: begin
                    r_state     <= S_WAIT;
                    r_bus_addr  <= WAIT_ADDR;
                    r_bus_wdata <= '0;
                    r_bus_we    <= 1'b0;
                    r_cnt       <= '0;
                end
                S_WAIT: begin
                    if (w_wait_done) begin
`ifdef FACCEL_SEQ_POLL_EN
                        r_res_err  <= bus_rdata[1];
                        r_state    <= S_RD_RES;
                        r_bus_addr <= ADDR_RESULT;
`else
                        r_state    <= S_RD_STAT;
                        r_bus_addr <= ADDR_STATUS;
`endif
                    end else if (r_cnt == TO_LAST) begin
                        r_res_data  <= '0;
                        r_res_err   <= 1'b1;
                        r_res_valid <= 1'b1;
                        r_state     <= S_RESP;
                        r_bus_addr  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RD_STAT: begin
                    r_res_err  <= bus_rdata[1];
                    r_state    <= S_RD_RES;
                    r_bus_addr <= ADDR_RESULT;
                end
                S_RD_RES: begin
                    r_res_data  <= bus_rdata;
                    r_res_valid <= 1'b1;
                    r_state     <= S_RESP;
                    r_bus_addr  <= '0;
                end
                S_RESP: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_res_valid <= 1'b0;
                    r_bus_addr  <= '0;
                    r_bus_wdata <= '0;
                    r_bus_we    <= 1'b0;
                end
            endcase
        end
    end

    assign job_ready = (r_state == S_IDLE);
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_err   = r_res_err;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_we    = r_bus_we;

endmodule

// File: tb/tb_faccel_job_seq.sv
// Randomized bench for faccel_job_seq: behavioural SoC/accelerator model plus a latency/result reference.
module tb_faccel_job_seq;

    localparam int unsigned TO = 32;
`ifdef FACCEL_SEQ_POLL_EN
    localparam int unsigned LAT_DONE = 5;
`else
    localparam int unsigned LAT_DONE = 6;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [3:0]  job_n = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_err;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic [31:0] bus_rdata;
    logic        bus_done;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Accelerator model controls: completion delay (edges after GO, 0 = never) and error flag.
    int unsigned cfg_delay = 0;
    logic        cfg_err = 1'b0;
    logic [3:0]  acc_n;
    logic        acc_done, acc_err, acc_busy;
    logic [31:0] acc_res;
    int unsigned acc_cnt;
    logic [63:0] wlog[$];

    faccel_job_seq #(
        .BASE_ADDR(32'h0000_0800),
        .TIMEOUT_CYCLES(TO),
        .TO_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .job_n(job_n),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .res_err(res_err),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_we(bus_we),
        .bus_rdata(bus_rdata),
        .bus_done(bus_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fact(input logic [3:0] n);
        logic [31:0] r;
        r = 32'd1;
        for (int unsigned i = 2; i <= 32'(n); i++) r = r * i;
        return r;
    endfunction

    always_comb begin
        bus_rdata = '0;
        case (bus_addr)
            32'h800: bus_rdata = {28'b0, acc_n};
            32'h808: bus_rdata = {30'b0, acc_err, acc_done};
            32'h80C: bus_rdata = acc_res;
            default: bus_rdata = '0;
        endcase
    end

    always @(posedge clk) begin
        if (!reset) begin
            acc_busy <= 1'b0; acc_done <= 1'b0; acc_err <= 1'b0;
            acc_res <= '0; acc_n <= '0; bus_done <= 1'b0; acc_cnt <= 0;
        end else begin
            if (bus_we) wlog.push_back({bus_addr, bus_wdata});
            if (bus_we && bus_addr == 32'h800) acc_n <= bus_wdata[3:0];
            if (bus_we && bus_addr == 32'h804 && bus_wdata[0]) begin
                acc_done <= 1'b0;
                acc_busy <= (cfg_delay != 0);
                acc_cnt  <= cfg_delay;
            end else if (acc_busy) begin
                acc_cnt <= acc_cnt - 1;
                if (acc_cnt == 1) begin
                    acc_busy <= 1'b0;
                    acc_done <= 1'b1;
                    acc_err  <= cfg_err;
                    acc_res  <= fact(acc_n);
                end
            end
            // Sticky done: completion sets it, any access to the accelerator window clears it.
            if (acc_busy && acc_cnt == 1 && !(bus_we && bus_addr == 32'h804 && bus_wdata[0]))
                bus_done <= 1'b1;
            else if (bus_addr[31:4] == 28'h000_0080)
                bus_done <= 1'b0;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic accept_job(input logic [3:0] n, input int unsigned d, input logic e);
        @(negedge clk);
        cfg_delay = d; cfg_err = e;
        wlog.delete();
        job_n = n; job_valid = 1'b1;
        @(posedge clk);
        #1 job_valid = 1'b0;
    endtask

    task automatic run_job(input logic [3:0] n, input int unsigned d, input logic e, input int unsigned hold);
        int unsigned exp_lat, k;
        logic [31:0] exp_data;
        logic exp_err;
        if (d != 0 && d <= TO) begin
            exp_lat = d + LAT_DONE; exp_data = fact(n); exp_err = e;
        end else begin
            exp_lat = TO + 4; exp_data = '0; exp_err = 1'b1;
        end
        accept_job(n, d, e);
        @(negedge clk);
        check_val("job_ready_busy", 32'(job_ready), 32'd0);
        k = 1;
        while (!res_valid && k < 300) begin
            @(posedge clk); @(negedge clk); k++;
        end
        check_val("latency", k, exp_lat);
        check_val("res_data", res_data, exp_data);
        check_val("res_err", 32'(res_err), 32'(exp_err));
        check_val("job_ready_resp", 32'(job_ready), 32'd0);
        check_val("wr_count", wlog.size(), 32'd3);
        if (wlog.size() == 3) begin
            check_val("wr0_addr", wlog[0][63:32], 32'h800);
            check_val("wr0_data", wlog[0][31:0], {28'b0, n});
            check_val("wr1", wlog[1][31:0] | (wlog[1][63:32] ^ 32'h804), 32'd1);
            check_val("wr2", wlog[2][31:0] | (wlog[2][63:32] ^ 32'h804), 32'd0);
        end
        for (int unsigned i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("hold_valid", 32'(res_valid), 32'd1);
            check_val("hold_data", res_data, exp_data);
            check_val("hold_err", 32'(res_err), 32'(exp_err));
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        check_val("post_valid", 32'(res_valid), 32'd0);
        check_val("post_ready", 32'(job_ready), 32'd1);
    endtask

    task automatic reset_mid_job(input int unsigned edges);
        accept_job(4'd9, 0, 1'b0);
        for (int unsigned i = 1; i < edges; i++) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_val("rst_we", 32'(bus_we), 32'd0);
        check_val("rst_addr", bus_addr, 32'd0);
        check_val("rst_valid", 32'(res_valid), 32'd0);
        check_val("rst_ready", 32'(job_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("rel_ready", 32'(job_ready), 32'd1);
    endtask

    initial begin
        #12;
        check_val("reset_ready", 32'(job_ready), 32'd1);
        check_val("reset_valid", 32'(res_valid), 32'd0);
        check_val("reset_data", res_data, 32'd0);
        check_val("reset_err", 32'(res_err), 32'd0);
        check_val("reset_we", 32'(bus_we), 32'd0);
        check_val("reset_addr", bus_addr, 32'd0);
        check_val("reset_wdata", bus_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_job(4'd5, 20, 1'b0, 0);       // 120
        run_job(4'd0, 7, 1'b0, 1);        // 0! = 1
        run_job(4'd13, 7, 1'b1, 0);       // error status, result register still read
        run_job(4'd6, 0, 1'b0, 0);        // timeout
        run_job(4'd4, 3, 1'b0, 5);        // held result
        run_job(4'd7, 1, 1'b0, 0);        // done on WAIT entry
        run_job(4'd8, TO, 1'b0, 0);       // done in final cycle beats timeout
        run_job(4'd8, TO + 1, 1'b0, 0);   // one cycle too late

        for (int unsigned j = 0; j < 12; j++) begin
            logic [3:0] rn;
            int unsigned rd;
            rn = 4'($urandom_range(0, 15));
            rd = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO + 4);
            run_job(rn, rd, ($urandom_range(0, 3) == 0), $urandom_range(0, 4));
        end

        reset_mid_job(1);   // during WR_N, bus_we high
        reset_mid_job(8);   // during WAIT
        run_job(4'd3, 5, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
